// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline hazard control slice
package pipe_pkg;
  typedef enum logic {RUN, STALL} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int STALL_MAX = 15;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode/ID-EX operand fields in, upstream pipeline control and perf counters out
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] if_id_rs;
  logic [4:0] if_id_rt;
  logic id_uses_rt;
  logic id_ex_memRead;
  logic [4:0] id_ex_rt;
  logic branch_taken;
  logic pc_write;
  logic if_id_write;
  logic id_ex_bubble;
  logic flush_if_id;
  logic flush_id_ex;
  logic flush_ex_mem;
  logic busy;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  modport master (
    output if_id_rs, if_id_rt, id_uses_rt, id_ex_memRead, id_ex_rt, branch_taken,
    input pc_write, if_id_write, id_ex_bubble, flush_if_id, flush_id_ex, flush_ex_mem, busy,
    input stall_count, flush_count
  );
  modport slave (
    input if_id_rs, if_id_rt, id_uses_rt, id_ex_memRead, id_ex_rt, branch_taken,
    output pc_write, if_id_write, id_ex_bubble, flush_if_id, flush_id_ex, flush_ex_mem, busy,
    output stall_count, flush_count
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (inc && count != '1) count <= count + W'(1);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall FSM and branch flush control for the 5-stage pipeline
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W = 16
) (
  input logic           clock,
  input logic           reset_n,
  hazard_ctrl_if.slave  bus
);
  localparam logic [3:0] CNT_INIT = 4'(STALL_CYCLES - 1);
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic hz, stall, flush;
  assign hz = bus.id_ex_memRead && bus.id_ex_rt != REG_ZERO &&
              (bus.id_ex_rt == bus.if_id_rs || (bus.id_uses_rt && bus.id_ex_rt == bus.if_id_rt));
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  // reset_n gates the Mealy outputs so a held reset shows reset values even with a live hazard
  always_comb begin
    flush    = reset_n && bus.branch_taken;
    stall    = reset_n && !flush && (state == STALL || hz);
    state_nx = state;
    cnt_nx   = cnt;
    if (flush) begin
      state_nx = RUN;
      cnt_nx   = '0;
    end else if (state == STALL) begin
      state_nx = (cnt == 4'd1) ? RUN : STALL;
      cnt_nx   = cnt - 4'd1;
    end else if (hz && STALL_CYCLES > 1) begin
      state_nx = STALL;
      cnt_nx   = CNT_INIT;
    end
  end
  assign bus.pc_write     = !stall;
  assign bus.if_id_write  = !stall;
  assign bus.id_ex_bubble = stall;
  assign bus.flush_if_id  = flush;
  assign bus.flush_id_ex  = flush;
  assign bus.flush_ex_mem = flush;
  assign bus.busy         = reset_n && state == STALL;
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock  (clock),
    .reset_n(reset_n),
    .inc    (stall),
    .count  (bus.stall_count)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock  (clock),
    .reset_n(reset_n),
    .inc    (flush),
    .count  (bus.flush_count)
  );
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Consumer-side companion to the ID/EX pipeline register in the 5-stage MIPS pipeline.
- Reads the registered ID/EX outputs (memRead, rt) and the decode-stage operand fields from IF/ID.
- Drives control back upstream: PC write-enable, IF/ID hold, ID/EX bubble insertion, and flushes on a branch taken in MEM.
- Contains a multi-cycle load-stall FSM and saturating performance counters.

Parameters:
- STALL_CYCLES, 1, consecutive stall cycles per load-use hazard (legal range 1..15).
- CNT_W, 16, width of the performance counters.

Ports:
- clock  in  1  pipeline clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- if_id_rs  in  5  rs field of the instruction in ID.
- if_id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source (R-type, beq, sw).
- id_ex_memRead  in  1  registered memRead from ID/EX.
- id_ex_rt  in  5  registered rt (load destination) from ID/EX.
- branch_taken  in  1  branch in the MEM stage resolved taken.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- id_ex_bubble  out  1  zero all ID/EX control bits on the next edge.
- flush_if_id  out  1  clear IF/ID on the next edge.
- flush_id_ex  out  1  clear ID/EX on the next edge.
- flush_ex_mem  out  1  clear EX/MEM control bits on the next edge.
- busy  out  1  FSM is in STALL.
- stall_count  out  CNT_W  cycles with pc_write=0 (saturating).
- flush_count  out  CNT_W  branch flush events (saturating).

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset_n` is asynchronous and active-low.
- During and after reset: state=RUN, stall counter=0, both perf counters=0.
- Reset output values: pc_write=1, if_id_write=1, id_ex_bubble=0, all flushes=0, busy=0.
- Hazard term: hz = id_ex_memRead & (id_ex_rt != 0) & ((id_ex_rt == if_id_rs) | (id_uses_rt & (id_ex_rt == if_id_rt))).
  - A load to $0 never stalls.
- Control outputs are combinational (Mealy) from state and inputs, with zero-cycle latency.
- Counters and FSM state are registered.
- State RUN:
  - If branch_taken: assert flush_if_id, flush_id_ex and flush_ex_mem. Keep pc_write=1 (PC takes the target). Stay in RUN. flush_count increments.
  - Else if hz: pc_write=0, if_id_write=0, id_ex_bubble=1. If STALL_CYCLES>1, go to STALL with cnt=STALL_CYCLES-1; else stay in RUN.
  - Else: pass-through, i.e. pc_write=1, if_id_write=1, no bubble, no flush.
- State STALL (busy=1):
  - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1.
  - hz is ignored, because the load has already left ID/EX.
  - cnt decrements each cycle. When cnt==1 on an edge, return to RUN.
  - If branch_taken: abort the stall. Assert all three flushes with pc_write=1, if_id_write=1, id_ex_bubble=0. Go to RUN with cnt=0. flush_count increments.
- Priority: branch_taken > hz > normal.
  - Flush outputs and stall outputs are never active in the same cycle.
- stall_count increments on every edge where pc_write==0. It saturates at all-ones and does not wrap.
- flush_count saturates in the same way.
- Reset mid-stall: immediately RUN, with outputs at their reset values asynchronously.
- Back-to-back loads (a second hazard the cycle after RUN resumes) start a fresh stall sequence with no dead cycle.
- All ports are two-state. X on id_ex_memRead is treated as a bench error, not handled.

Decomposition:
- Shared package pipe_pkg holds:
  - the state enum {RUN, STALL};
  - REG_ZERO = 5'd0;
  - the localparam for the STALL_CYCLES upper bound.
- One natural sub-module, sat_counter (parameter W; ports inc, clock, reset_n, count). It is instantiated twice, for stall_count and flush_count.
- Hazard compare logic and the FSM stay inline in hazard_ctrl.

Test Plan:
1. Reset, then hold reset_n=0 for 3 cycles with hz inputs active -> pc_write=1, if_id_write=1, all other outputs 0, counters 0.
2. STALL_CYCLES=1, id_ex_memRead=1, id_ex_rt=8, if_id_rs=8 for one cycle, then memRead=0 -> exactly 1 cycle of pc_write=0/id_ex_bubble=1, stall_count=1, busy stays 0.
3. STALL_CYCLES=3, same hazard via rt (if_id_rt=8, id_uses_rt=1), and id_uses_rt=0 control case -> 3 stall cycles, busy=1 for cycles 2–3, stall_count=3; with id_uses_rt=0 there is no stall.
4. Load with id_ex_rt=0 matching if_id_rs=0 -> no stall, stall_count stays 0.
5. STALL_CYCLES=4, branch_taken=1 in the 2nd stall cycle -> that cycle shows all flushes=1, pc_write=1, bubble=0; next cycle RUN; stall_count=1, flush_count=1.
6. CNT_W=4, continuous hazard for 20 cycles, plus 20 branch pulses -> stall_count and flush_count both saturate at 15. Also assert reset_n low mid-stall -> outputs return to reset values in the same cycle.
